// File: rtl/aes_key_expander.sv
// Sequential AES-128 key schedule: emits round keys 0..10, one per
// valid/ready handshake. RotWord comes from ShiftWordLeft (shiftSize=1);
// SubWord and Rcon are applied combinationally on the same cycle.
// Optional build macro: ROUNDKEY_STORE_EN adds an 11-entry round-key store
// with a combinational read port (readIndex/storedKey).

module ShiftWordLeft #(
  parameter int shiftSize = 1
) (
  input  logic [31:0] word,
  output logic [31:0] shifted
);
  // Byte-wise left rotation by shiftSize bytes.
  assign shifted = (word << (8 * shiftSize)) | (word >> (32 - 8 * shiftSize));
endmodule

module aes_key_expander #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] keyIn,
  input  logic         roundKeyReady,
`ifdef ROUNDKEY_STORE_EN
  input  logic [3:0]   readIndex,
  output logic [127:0] storedKey,
`endif
  output logic         roundKeyValid,
  output logic [127:0] roundKey,
  output logic [3:0]   roundIndex,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, EMIT} stateT;

  localparam logic [3:0] LAST_INDEX = 4'(NUM_ROUNDS);

  // AES S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  stateT        stateQ, stateD;
  logic         loadKey, advance, finish, handshake;
  logic [31:0]  rotW, subW, temp;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] nextKey;

  ShiftWordLeft #(.shiftSize(1)) rotWord (
    .word    (roundKey[31:0]),
    .shifted (rotW)
  );

  // Next round key from the current one: SubWord, Rcon, then the XOR chain.
  always_comb begin
    subW    = {SBOX[rotW[31:24]], SBOX[rotW[23:16]], SBOX[rotW[15:8]], SBOX[rotW[7:0]]};
    temp    = subW ^ {rcon(roundIndex + 4'd1), 24'h000000};
    n0      = roundKey[127:96] ^ temp;
    n1      = roundKey[95:64]  ^ n0;
    n2      = roundKey[63:32]  ^ n1;
    n3      = roundKey[31:0]   ^ n2;
    nextKey = {n0, n1, n2, n3};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) stateQ <= IDLE;
    else       stateQ <= stateD;
  end

  // Next-state decode and handshake-derived strobes; valid and busy follow EMIT.
  always_comb begin
    stateD        = stateQ;
    loadKey       = 1'b0;
    advance       = 1'b0;
    finish        = 1'b0;
    handshake     = 1'b0;
    roundKeyValid = 1'b0;
    busy          = 1'b0;
    case (stateQ)
      IDLE: begin
        if (start) begin
          loadKey = 1'b1;
          stateD  = EMIT;
        end
      end
      EMIT: begin
        roundKeyValid = 1'b1;
        busy          = 1'b1;
        if (roundKeyReady) begin
          handshake = 1'b1;
          if (roundIndex == LAST_INDEX) begin
            finish = 1'b1;
            stateD = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // Round key / index registers and the one-cycle done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      roundKey   <= '0;
      roundIndex <= '0;
      done       <= 1'b0;
    end else begin
      done <= finish;
      if (loadKey) begin
        roundKey   <= keyIn;
        roundIndex <= '0;
      end else if (advance) begin
        roundKey   <= nextKey;
        roundIndex <= roundIndex + 4'd1;
      end
    end
  end

`ifdef ROUNDKEY_STORE_EN
  logic [127:0] keyStore [0:10];

  // Capture every handed-off round key at its own index.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 11; i++) keyStore[i] <= '0;
    end else if (handshake && roundIndex <= 4'd10) begin
      keyStore[roundIndex] <= roundKey;
    end
  end

  assign storedKey = (readIndex <= 4'd10) ? keyStore[readIndex] : '0;
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 and all-zero key vectors.
// Build with ROUNDKEY_STORE_EN defined to also exercise the round-key store.

module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         reset, start, roundKeyReady;
  logic [127:0] keyIn;
  logic         roundKeyValid, busy, done;
  logic [127:0] roundKey;
  logic [3:0]   roundIndex;
`ifdef ROUNDKEY_STORE_EN
  logic [3:0]   readIndex;
  logic [127:0] storedKey;
`endif

  int checks = 0;
  int failures = 0;

  logic [127:0] fips [0:10];
  logic [127:0] fipsKey;
  localparam logic [127:0] ZERO_IDX1 = 128'h62636363626363636263636362636363;

  aes_key_expander #(.NUM_ROUNDS(10)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .keyIn         (keyIn),
    .roundKeyReady (roundKeyReady),
`ifdef ROUNDKEY_STORE_EN
    .readIndex     (readIndex),
    .storedKey     (storedKey),
`endif
    .roundKeyValid (roundKeyValid),
    .roundKey      (roundKey),
    .roundIndex    (roundIndex),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1; start = 1'b0; roundKeyReady = 1'b0; keyIn = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; roundKeyReady = 1'b0; keyIn = fipsKey;
    step(); step();
    @(negedge clk);
    checks++;
    if ({roundKeyValid, busy, done, roundIndex, roundKey} !== {3'b000, 4'd0, 128'h0}) begin
      failures++;
      $display("FAIL reset_state got v=%0b b=%0b d=%0b idx=%0d key=%h want all zero",
               roundKeyValid, busy, done, roundIndex, roundKey);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_fips();
    doReset();
    roundKeyReady = 1'b1;
    start = 1'b1; keyIn = fipsKey;
    step();
    start = 1'b0; keyIn = '0;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if ({roundKeyValid, busy, done, roundIndex, roundKey} !== {3'b110, 4'(i), fips[i]}) begin
        failures++;
        $display("FAIL fips_round%0d got v=%0b b=%0b d=%0b idx=%0d key=%h want v=1 b=1 d=0 idx=%0d key=%h",
                 i, roundKeyValid, busy, done, roundIndex, roundKey, i, fips[i]);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if ({roundKeyValid, busy, done, roundIndex, roundKey} !== {3'b001, 4'd10, fips[10]}) begin
      failures++;
      $display("FAIL fips_done got v=%0b b=%0b d=%0b idx=%0d key=%h want v=0 b=0 d=1 idx=10 key=%h",
               roundKeyValid, busy, done, roundIndex, roundKey, fips[10]);
    end
    step();
    @(negedge clk);
    checks++;
    if ({roundKeyValid, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL fips_done_width got v=%0b b=%0b d=%0b want 000", roundKeyValid, busy, done);
    end
`ifdef ROUNDKEY_STORE_EN
    readIndex = 4'd10; #1;
    checks++;
    if (storedKey !== fips[10]) begin
      failures++; $display("FAIL store_idx10 got %h want %h", storedKey, fips[10]);
    end
    readIndex = 4'd0; #1;
    checks++;
    if (storedKey !== fipsKey) begin
      failures++; $display("FAIL store_idx0 got %h want %h", storedKey, fipsKey);
    end
    readIndex = 4'd5; #1;
    checks++;
    if (storedKey !== fips[5]) begin
      failures++; $display("FAIL store_idx5 got %h want %h", storedKey, fips[5]);
    end
    readIndex = 4'd12; #1;
    checks++;
    if (storedKey !== 128'h0) begin
      failures++; $display("FAIL store_idx12 got %h want 0", storedKey);
    end
    readIndex = 4'd0;
`endif
  endtask

  // Backpressure at idx3, then start while busy at idx4 and on the final handshake.
  task automatic test_backpressure_and_busy_start();
    doReset();
    roundKeyReady = 1'b1;
    start = 1'b1; keyIn = fipsKey;
    step();
    start = 1'b0;
    step(); step(); step();
    roundKeyReady = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({roundKeyValid, roundIndex, roundKey} !== {1'b1, 4'd3, 128'h3d80477d4716fe3e1e237e446d7a883b}) begin
        failures++;
        $display("FAIL hold_idx3_cycle%0d got v=%0b idx=%0d key=%h want v=1 idx=3 key=3d80477d4716fe3e1e237e446d7a883b",
                 c, roundKeyValid, roundIndex, roundKey);
      end
      step();
    end
    roundKeyReady = 1'b1;
    step();
    start = 1'b1; keyIn = '0;
    for (int i = 4; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if ({roundKeyValid, busy, roundIndex, roundKey} !== {2'b11, 4'(i), fips[i]}) begin
        failures++;
        $display("FAIL busy_start_round%0d got v=%0b b=%0b idx=%0d key=%h want v=1 b=1 idx=%0d key=%h",
                 i, roundKeyValid, busy, roundIndex, roundKey, i, fips[i]);
      end
      step();
      if (i == 4) start = 1'b0;
      if (i == 9) start = 1'b1;
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({roundKeyValid, done, roundIndex} !== {2'b01, 4'd10}) begin
      failures++;
      $display("FAIL final_start_ignored got v=%0b d=%0b idx=%0d want v=0 d=1 idx=10",
               roundKeyValid, done, roundIndex);
    end
    step();
    @(negedge clk);
    checks++;
    if ({roundKeyValid, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL final_start_idle got v=%0b b=%0b d=%0b want 000", roundKeyValid, busy, done);
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    roundKeyReady = 1'b1;
    start = 1'b1; keyIn = fipsKey;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    @(negedge clk);
    checks++;
    if (roundIndex !== 4'd6) begin
      failures++; $display("FAIL reset_mid_reach got idx=%0d want 6", roundIndex);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({roundKeyValid, busy, done, roundIndex, roundKey} !== {3'b000, 4'd0, 128'h0}) begin
      failures++;
      $display("FAIL reset_mid got v=%0b b=%0b d=%0b idx=%0d key=%h want all zero",
               roundKeyValid, busy, done, roundIndex, roundKey);
    end
    step();
    @(negedge clk);
    checks++;
    if ({roundKeyValid, done} !== 2'b00) begin
      failures++; $display("FAIL reset_mid_nodone got v=%0b d=%0b want 00", roundKeyValid, done);
    end
    start = 1'b1; keyIn = '0;
    step();
    start = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if ({roundKeyValid, roundIndex, roundKey} !== {1'b1, 4'd1, ZERO_IDX1}) begin
      failures++;
      $display("FAIL zero_key_idx1 got v=%0b idx=%0d key=%h want v=1 idx=1 key=%h",
               roundKeyValid, roundIndex, roundKey, ZERO_IDX1);
    end
  endtask

  task automatic test_back_to_back();
    int budget;
    doReset();
    roundKeyReady = 1'b1;
    start = 1'b1; keyIn = fipsKey;
    step();
    start = 1'b0;
    budget = 0;
    while (done !== 1'b1 && budget < 40) begin
      step();
      budget++;
    end
    checks++;
    if (done !== 1'b1 || budget !== 11) begin
      failures++;
      $display("FAIL b2b_done_timing got done=%0b after %0d cycles want done=1 after 11", done, budget);
    end
    start = 1'b1; keyIn = '0;
    step();
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({roundKeyValid, busy, done, roundIndex, roundKey} !== {3'b110, 4'd0, 128'h0}) begin
      failures++;
      $display("FAIL b2b_idx0 got v=%0b b=%0b d=%0b idx=%0d key=%h want v=1 b=1 d=0 idx=0 key=0",
               roundKeyValid, busy, done, roundIndex, roundKey);
    end
    step();
    @(negedge clk);
    checks++;
    if ({roundIndex, roundKey} !== {4'd1, ZERO_IDX1}) begin
      failures++;
      $display("FAIL b2b_idx1 got idx=%0d key=%h want idx=1 key=%h", roundIndex, roundKey, ZERO_IDX1);
    end
  endtask

  initial begin
    fipsKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    reset = 1'b1; start = 1'b0; roundKeyReady = 1'b0; keyIn = '0;
`ifdef ROUNDKEY_STORE_EN
    readIndex = 4'd0;
`endif
    test_reset();
    test_fips();
    test_backpressure_and_busy_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
